event_counter_bank: RTL and testbench
=====================================

Name: event_counter_bank

Overview:
- N-channel, WIDTH-bit event counter bank; the parametrised successor to the single 16-bit event counter.
- Adds per-channel synchronous clear, a programmable terminal count, and wrap or saturate mode.
- Adds optional rising-edge qualification of events and a terminal-count pulse per channel.
- Adds an atomic snapshot of all channels, streamed out over a valid/ready port; used for statistics and performance counters in lab designs.

Parameters:
- N_CHAN, 4, number of independent channels (>=1).
- WIDTH, 16, counter width in bits (>=2).
- EVT_EDGE, 0, 0 = count every cycle evt_in is high; 1 = count rising edges of evt_in only.

Ports:
- clk_in  in  1  sole clock.
- rst_in  in  1  reset, asynchronous, active-high.
- evt_in  in  N_CHAN  per-channel event.
- clr_in  in  N_CHAN  per-channel synchronous clear.
- mode_in  in  1  0 = wrap, 1 = saturate; shared by all channels.
- max_in  in  WIDTH  terminal count, shared; sampled every cycle.
- snap_in  in  1  snapshot request.
- count_out  out  N_CHAN*WIDTH  live counts; channel i occupies [i*WIDTH +: WIDTH].
- tc_out  out  N_CHAN  one-cycle terminal-count pulse per channel.
- rd_valid_out  out  1  snapshot word valid.
- rd_ready_in  in  1  consumer ready.
- rd_chan_out  out  max(1,$clog2(N_CHAN))  channel index of the current word.
- rd_data_out  out  WIDTH  snapshot value.
- rd_last_out  out  1  high with the word for channel N_CHAN-1.
- busy_out  out  1  readout in progress.

Behaviour:
- Reset: asynchronous assert; all outputs 0, including counts, tc_out, rd_* and busy_out. Shadow registers, FSM and edge-detect history are also cleared.
- Accepted event:
  - EVT_EDGE=0: evt_in[i]=1.
  - EVT_EDGE=1: evt_in[i]=1 and previous-cycle evt_in[i]=0. History resets to 0, so a high input at the first post-reset edge counts once.
- Per-channel priority each edge: clr_in > accepted event > hold. Clear sets the count to 0 and suppresses tc.
- Wrap mode, accepted event:
  - count < max_in: count+1.
  - count >= max_in: count becomes 0 and tc_out[i] pulses.
- Saturate mode, accepted event:
  - count < max_in: count+1; tc_out[i] pulses if the result equals max_in.
  - count >= max_in: count becomes max_in, no pulse. This also clamps a count left above a lowered max_in.
- max_in = 0: wrap mode holds the count at 0 and pulses tc on every event; saturate mode holds 0 with no pulse.
- All arithmetic is unsigned, WIDTH bits. max_in = 2^WIDTH-1 gives a full-range counter.
- tc_out is registered and aligned with the count update, i.e. it is visible in the same cycle as the new count_out.
- Snapshot FSM:
  - States: IDLE, SEND.
  - IDLE: snap_in=1 at edge k copies every channel's count_out as held during cycle k (the pre-update value) into the shadow registers. The FSM enters SEND with index 0, and rd_valid_out and busy_out are high from cycle k+1.
  - SEND: rd_chan_out = index and rd_data_out = shadow[index]. These are held stable while valid && !ready.
  - On valid&&ready with index < N_CHAN-1: index+1, and the next word is presented in the next cycle with no bubble.
  - On valid&&ready with index == N_CHAN-1 (rd_last_out=1): return to IDLE; valid and busy drop next cycle.
  - snap_in while in SEND is ignored (not queued).
  - A new snapshot may be accepted in the cycle after busy_out falls.
- Live counters keep running during SEND; the shadow registers are unaffected.
- snap_in coinciding with clr_in or an event captures the pre-clear/pre-increment value.
- Reset mid-readout aborts the stream immediately; rd_valid_out drops asynchronously.

Decomposition:
- Package event_counter_pkg:
  - typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e.
  - typedef enum logic {RD_IDLE, RD_SEND} rd_state_e.
- Sub-module event_counter_chan: one channel holding edge detect, count and tc. It is instantiated N_CHAN times via a generate loop.
- The top level holds the shadow array, readout FSM and index counter.

Test Plan:
- Wrap: N_CHAN=4, WIDTH=8, mode=0, max=5, 7 level events on ch0 -> counts 1,2,3,4,5,0,1; tc_out[0] pulses only with 0; other channels stay 0.
- Saturate with runtime change: mode=1, max=3, 5 events -> 1,2,3,3,3 and a single tc pulse with 3. Set max=2, one event -> count 2, no tc.
- Clear priority and edges: EVT_EDGE=1, evt held high 10 cycles -> count 1. Assert clr and a rising edge in the same cycle -> count 0, no tc.
- Snapshot with backpressure:
  - Setup: counts {7,0,200,255}; snap_in while ch0 increments -> stream shows 7,0,200,255 for channels 0..3.
  - rd_ready toggling 1,0,0,1 -> data stable while stalled.
  - rd_last only on channel 3; busy falls after the 4th handshake.
- Snapshot ignored while busy: snap_in pulses during SEND -> no restart, exactly 4 words emitted; a snap accepted the cycle after busy falls starts a new stream.
- Async reset mid-stream: assert rst_in between clock edges during SEND -> rd_valid_out, busy_out, count_out and tc_out are 0 before the next edge. After release, snap_in streams all zeros.

Source files
------------

// File: rtl/event_counter_pkg.sv
// Shared types for the event counter bank: counting mode and readout state.
package event_counter_pkg;

   typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;

   typedef enum logic {RD_IDLE = 1'b0, RD_SEND = 1'b1} rd_state_e;

   // Width of a channel index; a single-channel bank still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/event_counter_chan.sv
// One counter channel: optional rising-edge qualification, clear, wrap or
// saturate against a shared terminal count, and a registered tc pulse.
module event_counter_chan
   import event_counter_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int EVT_EDGE = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             evt_i,
   input  logic             clr_i,
   input  cnt_mode_e        mode_i,
   input  logic [WIDTH-1:0] max_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             evt_prev_q;
   logic             evt_acc;
   logic [WIDTH-1:0] cnt_inc;

   assign evt_acc = (EVT_EDGE != 0) ? (evt_i & ~evt_prev_q) : evt_i;
   assign cnt_inc = cnt_q + WIDTH'(1);

   // Next count: clear wins over an event; a count at or above max_i
   // (possibly because max_i was lowered) wraps to 0 or clamps to max_i.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (evt_acc) begin
         if (cnt_q < max_i) begin
            cnt_d = cnt_inc;
            tc_d  = (mode_i == CNT_SAT) && (cnt_inc == max_i);
         end else begin
            cnt_d = (mode_i == CNT_SAT) ? max_i : '0;
            tc_d  = (mode_i == CNT_WRAP);
         end
      end
   end

   // Count, tc pulse and edge history registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         tc_q       <= 1'b0;
         evt_prev_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         tc_q       <= tc_d;
         evt_prev_q <= evt_i;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = tc_q;

endmodule

// File: rtl/event_counter_bank.sv
// N-channel event counter bank with an atomic snapshot of all live counts,
// streamed out one channel per word over a valid/ready port.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  RD_IDLE | no readout; snap_in captures all live counts into the shadow
//  RD_SEND | presenting shadow[idx]; advance on each valid&&ready handshake
module event_counter_bank
   import event_counter_pkg::*;
#(
   parameter int N_CHAN   = 4,
   parameter int WIDTH    = 16,
   parameter int EVT_EDGE = 0
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic [N_CHAN-1:0]               evt_in,
   input  logic [N_CHAN-1:0]               clr_in,
   input  logic                            mode_in,
   input  logic [WIDTH-1:0]                max_in,
   input  logic                            snap_in,
   output logic [N_CHAN*WIDTH-1:0]         count_out,
   output logic [N_CHAN-1:0]               tc_out,
   output logic                            rd_valid_out,
   input  logic                            rd_ready_in,
   output logic [idx_width(N_CHAN)-1:0]    rd_chan_out,
   output logic [WIDTH-1:0]                rd_data_out,
   output logic                            rd_last_out,
   output logic                            busy_out
);

   localparam int IDX_W = idx_width(N_CHAN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHAN - 1);

   cnt_mode_e          mode_e;
   logic [N_CHAN*WIDTH-1:0] cnt_w;
   logic [WIDTH-1:0]   shadow_q [N_CHAN];
   rd_state_e          state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               snap_load;

   assign mode_e = cnt_mode_e'(mode_in);

   for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
      event_counter_chan #(
         .WIDTH    (WIDTH),
         .EVT_EDGE (EVT_EDGE)
      ) u_chan (
         .clk_i  (clk_in),
         .rst_i  (rst_in),
         .evt_i  (evt_in[i]),
         .clr_i  (clr_in[i]),
         .mode_i (mode_e),
         .max_i  (max_in),
         .cnt_o  (cnt_w[i*WIDTH +: WIDTH]),
         .tc_o   (tc_out[i])
      );
   end

   // Readout next state: snapshots are only taken from idle, so a request
   // during a stream is dropped rather than queued.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      snap_load = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (snap_in) begin
               snap_load = 1'b1;
               state_d   = RD_SEND;
               idx_d     = '0;
            end
         end
         RD_SEND: begin
            if (rd_ready_in) begin
               if (idx_q == LAST_IDX) begin
                  state_d = RD_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = RD_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Readout state and word index registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= RD_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Shadow capture of the counts held this cycle, i.e. before this edge's
   // clear or increment lands.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < N_CHAN; i++) shadow_q[i] <= '0;
      end else if (snap_load) begin
         for (int i = 0; i < N_CHAN; i++) shadow_q[i] <= cnt_w[i*WIDTH +: WIDTH];
      end
   end

   assign count_out    = cnt_w;
   assign rd_valid_out = (state_q == RD_SEND);
   assign busy_out     = (state_q == RD_SEND);
   assign rd_chan_out  = idx_q;
   assign rd_data_out  = shadow_q[idx_q];
   assign rd_last_out  = (state_q == RD_SEND) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_event_counter_bank.sv
// Bench for event_counter_bank: a level-counting and an edge-counting
// instance share stimulus and are compared against a cycle model.
module tb_event_counter_bank;

   localparam int N = 4;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  evt = '0;
   logic [N-1:0]  clr = '0;
   logic          mode = 1'b0;
   logic [W-1:0]  mx = '0;
   logic          snap = 1'b0;
   logic          rd_ready = 1'b0;

   logic [N*W-1:0] cnt_l, cnt_e;
   logic [N-1:0]   tc_l, tc_e;
   logic           rdv_l, rdv_e, rdl_l, rdl_e, busy_l, busy_e;
   logic [1:0]     rdc_l, rdc_e;
   logic [W-1:0]   rdd_l, rdd_e;

   int n_chk = 0;
   int n_err = 0;

   // model state: [0] = level instance, [1] = edge instance
   int m_cnt [2][N];
   bit m_tc  [2][N];
   bit m_prev [N];
   int q_l[$];
   int q_e[$];

   always #5 clk = ~clk;

   event_counter_bank #(.N_CHAN(N), .WIDTH(W), .EVT_EDGE(0)) u_lvl (
      .clk_in(clk), .rst_in(rst), .evt_in(evt), .clr_in(clr), .mode_in(mode),
      .max_in(mx), .snap_in(snap), .count_out(cnt_l), .tc_out(tc_l),
      .rd_valid_out(rdv_l), .rd_ready_in(rd_ready), .rd_chan_out(rdc_l),
      .rd_data_out(rdd_l), .rd_last_out(rdl_l), .busy_out(busy_l));

   event_counter_bank #(.N_CHAN(N), .WIDTH(W), .EVT_EDGE(1)) u_edg (
      .clk_in(clk), .rst_in(rst), .evt_in(evt), .clr_in(clr), .mode_in(mode),
      .max_in(mx), .snap_in(snap), .count_out(cnt_e), .tc_out(tc_e),
      .rd_valid_out(rdv_e), .rd_ready_in(rd_ready), .rd_chan_out(rdc_e),
      .rd_data_out(rdd_e), .rd_last_out(rdl_e), .busy_out(busy_e));

   task automatic m_reset();
      for (int v = 0; v < 2; v++)
         for (int i = 0; i < N; i++) begin
            m_cnt[v][i] = 0;
            m_tc[v][i]  = 0;
         end
      for (int i = 0; i < N; i++) m_prev[i] = 0;
      q_l.delete();
      q_e.delete();
   endtask

   // One clock edge of the reference behaviour, using the inputs held now.
   task automatic model_edge();
      bit acc;
      int mxi;
      if (rst) begin
         m_reset();
         return;
      end
      mxi = int'(mx);
      if (q_l.size() == 0) begin
         if (snap)
            for (int i = 0; i < N; i++) begin
               q_l.push_back(m_cnt[0][i]);
               q_e.push_back(m_cnt[1][i]);
            end
      end else if (rd_ready) begin
         void'(q_l.pop_front());
         void'(q_e.pop_front());
      end
      for (int v = 0; v < 2; v++)
         for (int i = 0; i < N; i++) begin
            acc = (v == 0) ? evt[i] : (evt[i] && !m_prev[i]);
            m_tc[v][i] = 0;
            if (clr[i]) m_cnt[v][i] = 0;
            else if (acc) begin
               if (mode == 1'b0) begin
                  if (m_cnt[v][i] < mxi) m_cnt[v][i] = m_cnt[v][i] + 1;
                  else begin
                     m_cnt[v][i] = 0;
                     m_tc[v][i]  = 1;
                  end
               end else begin
                  if (m_cnt[v][i] < mxi) begin
                     m_cnt[v][i] = m_cnt[v][i] + 1;
                     m_tc[v][i]  = (m_cnt[v][i] == mxi);
                  end else m_cnt[v][i] = mxi;
               end
            end
         end
      for (int i = 0; i < N; i++) m_prev[i] = evt[i];
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic logic [N*W-1:0] exp_cnt(input int v);
      logic [N*W-1:0] r;
      int c;
      for (int i = 0; i < N; i++) begin
         c = m_cnt[v][i];
         r[i*W +: W] = c[W-1:0];
      end
      return r;
   endfunction

   function automatic logic [N-1:0] exp_tc(input int v);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_tc[v][i];
      return r;
   endfunction

   task automatic test_reset();
      m_reset();
      rst = 1'b1;
      #12;
      n_chk++; if ({cnt_l, cnt_e} !== '0) begin n_err++; $display("FAIL reset_count got=%h exp=0", {cnt_l, cnt_e}); end
      n_chk++; if ({tc_l, tc_e} !== '0) begin n_err++; $display("FAIL reset_tc got=%h exp=0", {tc_l, tc_e}); end
      n_chk++; if ({rdv_l, rdv_e, busy_l, busy_e, rdl_l, rdl_e} !== '0) begin n_err++; $display("FAIL reset_ctrl got=%b exp=0", {rdv_l, rdv_e, busy_l, busy_e, rdl_l, rdl_e}); end
      n_chk++; if ({rdc_l, rdd_l, rdc_e, rdd_e} !== '0) begin n_err++; $display("FAIL reset_rd got=%h exp=0", {rdc_l, rdd_l, rdc_e, rdd_e}); end
      @(negedge clk);
      rst = 1'b0;
      #4;
   endtask

   task automatic test_wrap();
      int seq [7] = '{1, 2, 3, 4, 5, 0, 1};
      mode = 1'b0; mx = 8'd5; evt = 4'b0001;
      for (int k = 0; k < 7; k++) begin
         tick();
         n_chk++; if (cnt_l[W-1:0] !== W'(seq[k])) begin n_err++; $display("FAIL wrap_ch0 step=%0d got=%0d exp=%0d", k, cnt_l[W-1:0], seq[k]); end
         n_chk++; if (tc_l !== ((k == 5) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL wrap_tc step=%0d got=%b", k, tc_l); end
         n_chk++; if (cnt_l !== exp_cnt(0)) begin n_err++; $display("FAIL wrap_lvl got=%h exp=%h", cnt_l, exp_cnt(0)); end
         n_chk++; if (cnt_e !== exp_cnt(1) || tc_e !== exp_tc(1)) begin n_err++; $display("FAIL wrap_edg got=%h/%b exp=%h/%b", cnt_e, tc_e, exp_cnt(1), exp_tc(1)); end
      end
      evt = '0;
   endtask

   task automatic test_saturate();
      int seq [5] = '{1, 2, 3, 3, 3};
      clr = '1; tick(); clr = '0;
      mode = 1'b1; mx = 8'd3; evt = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_chk++; if (cnt_l[W-1:0] !== W'(seq[k])) begin n_err++; $display("FAIL sat_ch0 step=%0d got=%0d exp=%0d", k, cnt_l[W-1:0], seq[k]); end
         n_chk++; if (tc_l !== ((k == 2) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL sat_tc step=%0d got=%b", k, tc_l); end
         n_chk++; if (cnt_e !== exp_cnt(1)) begin n_err++; $display("FAIL sat_edg got=%h exp=%h", cnt_e, exp_cnt(1)); end
      end
      mx = 8'd2;
      tick();
      n_chk++; if (cnt_l[W-1:0] !== 8'd2 || tc_l !== 4'b0000) begin n_err++; $display("FAIL sat_lower got=%0d tc=%b exp=2 tc=0", cnt_l[W-1:0], tc_l); end
      n_chk++; if (cnt_l !== exp_cnt(0)) begin n_err++; $display("FAIL sat_lower_all got=%h exp=%h", cnt_l, exp_cnt(0)); end
      evt = '0;
   endtask

   task automatic test_clear_edge();
      clr = '1; tick(); clr = '0;
      mode = 1'b0; mx = 8'd255; evt = 4'b0010;
      for (int k = 0; k < 10; k++) tick();
      n_chk++; if (cnt_e[W +: W] !== 8'd1) begin n_err++; $display("FAIL edge_held got=%0d exp=1", cnt_e[W +: W]); end
      n_chk++; if (cnt_l[W +: W] !== 8'd10) begin n_err++; $display("FAIL level_held got=%0d exp=10", cnt_l[W +: W]); end
      evt = '0; tick();
      evt = 4'b0010; clr = 4'b0010; tick();
      n_chk++; if (cnt_e[W +: W] !== 8'd0 || tc_e[1] !== 1'b0) begin n_err++; $display("FAIL clr_prio got=%0d tc=%b exp=0 tc=0", cnt_e[W +: W], tc_e[1]); end
      n_chk++; if (cnt_l !== exp_cnt(0) || cnt_e !== exp_cnt(1)) begin n_err++; $display("FAIL clr_all got=%h/%h exp=%h/%h", cnt_l, cnt_e, exp_cnt(0), exp_cnt(1)); end
      clr = '0; evt = '0;
   endtask

   task automatic test_snapshot_bp();
      int tbl [4] = '{7, 0, 200, 255};
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int words = 0;
      int k = 0;
      int mch;
      clr = '1; tick(); clr = '0;
      mode = 1'b1; mx = 8'd255;
      for (int i = 0; i < 255; i++) begin
         evt = {1'b1, (i < 200), 1'b0, (i < 7)};
         tick();
      end
      evt = 4'b0001; snap = 1'b1; rd_ready = 1'b0;
      tick();
      evt = '0; snap = 1'b0;
      n_chk++; if (cnt_l[W-1:0] !== 8'd8) begin n_err++; $display("FAIL snap_live got=%0d exp=8", cnt_l[W-1:0]); end
      while (words < 4 && k < 20) begin
         rd_ready = pat[k % 4];
         mch = N - q_l.size();
         n_chk++; if (rdv_l !== 1'b1 || busy_l !== 1'b1 || rdv_e !== 1'b1) begin n_err++; $display("FAIL bp_valid k=%0d got=%b%b%b exp=111", k, rdv_l, busy_l, rdv_e); end
         n_chk++; if (rdc_l !== 2'(mch) || rdd_l !== 8'(tbl[mch])) begin n_err++; $display("FAIL bp_word k=%0d got=ch%0d:%0d exp=ch%0d:%0d", k, rdc_l, rdd_l, mch, tbl[mch]); end
         n_chk++; if (rdd_e !== 8'(q_e[0]) || rdc_e !== 2'(mch)) begin n_err++; $display("FAIL bp_edg k=%0d got=ch%0d:%0d exp=ch%0d:%0d", k, rdc_e, rdd_e, mch, q_e[0]); end
         n_chk++; if (rdl_l !== (mch == N - 1)) begin n_err++; $display("FAIL bp_last k=%0d got=%b exp=%b", k, rdl_l, (mch == N - 1)); end
         if (rdv_l && rd_ready) words++;
         tick();
         k++;
      end
      n_chk++; if (words !== 4) begin n_err++; $display("FAIL bp_words got=%0d exp=4", words); end
      n_chk++; if (busy_l !== 1'b0 || rdv_l !== 1'b0 || busy_e !== 1'b0) begin n_err++; $display("FAIL bp_done got=%b%b%b exp=000", busy_l, rdv_l, busy_e); end
      rd_ready = 1'b0;
   endtask

   task automatic test_snap_ignored();
      logic [5:0] got;
      logic [5:0] expv = 6'b101111;
      snap = 1'b1; rd_ready = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         got[k] = rdv_l;
         n_chk++; if (rdv_l !== (q_l.size() > 0) || busy_e !== (q_e.size() > 0)) begin n_err++; $display("FAIL ign_model k=%0d got=%b/%b exp=%b", k, rdv_l, busy_e, (q_l.size() > 0)); end
         tick();
      end
      n_chk++; if (got !== expv) begin n_err++; $display("FAIL ign_pattern got=%b exp=%b", got, expv); end
      snap = 1'b0;
      for (int k = 0; k < 8 && q_l.size() > 0; k++) tick();
      n_chk++; if (rdv_l !== 1'b0 || q_l.size() != 0) begin n_err++; $display("FAIL ign_drain got=%b exp=0", rdv_l); end
      rd_ready = 1'b0;
   endtask

   task automatic test_random();
      int sel;
      logic [W-1:0] mx_tbl [7] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd9, 8'd255};
      for (int k = 0; k < 400; k++) begin
         if (k % 40 == 0) begin
            sel  = int'($urandom_range(0, 6));
            mx   = mx_tbl[sel];
            mode = 1'($urandom);
         end
         evt      = 4'($urandom);
         clr      = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
         snap     = ($urandom_range(0, 7) == 0);
         rd_ready = 1'($urandom);
         tick();
         n_chk++; if (cnt_l !== exp_cnt(0) || tc_l !== exp_tc(0)) begin n_err++; $display("FAIL rnd_lvl k=%0d got=%h/%b exp=%h/%b", k, cnt_l, tc_l, exp_cnt(0), exp_tc(0)); end
         n_chk++; if (cnt_e !== exp_cnt(1) || tc_e !== exp_tc(1)) begin n_err++; $display("FAIL rnd_edg k=%0d got=%h/%b exp=%h/%b", k, cnt_e, tc_e, exp_cnt(1), exp_tc(1)); end
         n_chk++; if (rdv_l !== (q_l.size() > 0) || busy_l !== (q_l.size() > 0) || rdl_l !== (q_l.size() == 1)) begin n_err++; $display("FAIL rnd_ctrl k=%0d got=%b%b%b qsize=%0d", k, rdv_l, busy_l, rdl_l, q_l.size()); end
         if (q_l.size() > 0) begin
            n_chk++; if (rdc_l !== 2'(N - q_l.size()) || rdd_l !== 8'(q_l[0]) || rdd_e !== 8'(q_e[0])) begin n_err++; $display("FAIL rnd_word k=%0d got=ch%0d:%0d/%0d exp=ch%0d:%0d/%0d", k, rdc_l, rdd_l, rdd_e, N - q_l.size(), q_l[0], q_e[0]); end
         end
      end
      snap = 1'b0; clr = '0; evt = '0; rd_ready = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      rd_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      mode = 1'b0; mx = 8'd255; evt = 4'b1111;
      tick(); tick();
      evt = '0; snap = 1'b1; rd_ready = 1'b0;
      tick();
      snap = 1'b0;
      tick();
      n_chk++; if (rdv_l !== 1'b1) begin n_err++; $display("FAIL ar_started got=%b exp=1", rdv_l); end
      #3 rst = 1'b1;
      #1;
      n_chk++; if ({rdv_l, busy_l, rdv_e, busy_e} !== 4'b0000) begin n_err++; $display("FAIL ar_ctrl got=%b exp=0000", {rdv_l, busy_l, rdv_e, busy_e}); end
      n_chk++; if ({cnt_l, cnt_e, tc_l, tc_e} !== '0) begin n_err++; $display("FAIL ar_cnt got=%h exp=0", {cnt_l, cnt_e}); end
      m_reset();
      tick();
      #2 rst = 1'b0;
      snap = 1'b1;
      tick();
      snap = 1'b0; rd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_chk++; if (rdv_l !== 1'b1 || rdd_l !== 8'd0 || rdd_e !== 8'd0 || rdc_l !== 2'(k)) begin n_err++; $display("FAIL ar_zero k=%0d got=v%b ch%0d:%0d/%0d exp=v1 ch%0d:0/0", k, rdv_l, rdc_l, rdd_l, rdd_e, k); end
         tick();
      end
      n_chk++; if (busy_l !== 1'b0) begin n_err++; $display("FAIL ar_end got=%b exp=0", busy_l); end
      rd_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_saturate();
      test_clear_edge();
      test_snapshot_bp();
      test_snap_ignored();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
